// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
// Runs a 32-iteration radix-2 restoring divider on operand magnitudes and
// stalls the pipeline while it works. Divide-by-zero and signed overflow are
// resolved in one cycle. The result is presented for one cycle with done.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] div_r;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;

    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            sig_ovf;
    logic [XLEN-1:0] special_val;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_val;
    logic            accept;
    logic [1:0]      unused_bits;

    // Operand conditioning: magnitudes, sign flags and single-cycle special cases
    always_comb begin
        op_signed   = ~func3[0];
        a_neg       = op_signed & op_a[XLEN-1];
        b_neg       = op_signed & op_b[XLEN-1];
        abs_a       = a_neg ? (~op_a + 1'b1) : op_a;
        abs_b       = b_neg ? (~op_b + 1'b1) : op_b;
        div_zero    = (op_b == '0);
        sig_ovf     = op_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special_val = '0;
        if (div_zero)
            special_val = func3[1] ? op_a : '1;
        else
            special_val = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One restoring-division trial subtraction and the final sign fix-up
    always_comb begin
        shifted = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
        trial   = shifted - {1'b0, div_r};
        fix_val = '0;
        if (is_rem)
            fix_val = neg_r ? (~rem_r[XLEN-1:0] + 1'b1) : rem_r[XLEN-1:0];
        else
            fix_val = neg_q ? (~quo_r + 1'b1) : quo_r;
    end

    // Stall from start depends only on control, never on operand values
    assign accept      = start & ~flush & (state == IDLE);
    assign stall       = accept | (state == CALC) | (state == FIX);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign unused_bits = {func3[2], rem_r[XLEN]};

    // Sequencer state, datapath registers and held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            div_r  <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_out <= rd_in;
                        is_rem <= func3[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        quo_r  <= abs_a;
                        div_r  <= abs_b;
                        rem_r  <= '0;
                        cnt    <= '0;
                        if (div_zero || sig_ovf) begin
                            result <= special_val;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[XLEN])
                        rem_r <= trial;
                    else
                        rem_r <= shifted;
                    quo_r <= {quo_r[XLEN-2:0], ~trial[XLEN]};
                    if (cnt == CNT_W'(XLEN-1))
                        state <= FIX;
                    else
                        cnt <= cnt + 1'b1;
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed test of the divide sequencer with
// hand-computed quotients, remainders and cycle-exact handshake timing.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int assert_count;
    int fail_count;

    div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
        start = s;
        func3 = f;
        op_a  = a;
        op_b  = b;
        rd_in = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive an operation starting in the current cycle and check every cycle up to done
    task automatic runOp(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res,
                         input int lat, input int ignore_at);
        applyStimulus(1'b1, f, a, b, rd);
        #1;
        checkOutput({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == ignore_at)
                applyStimulus(1'b1, 3'b101, 32'd1000, 32'd3, 5'd9);
            else
                applyStimulus(1'b0, f, a, b, rd);
            #1;
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == lat) begin
                checkOutput({tag, "_done"},   {31'd0, done},  32'd1);
                checkOutput({tag, "_stall"},  {31'd0, stall}, 32'd0);
                checkOutput({tag, "_result"}, result, exp_res);
                checkOutput({tag, "_rd"},     {27'd0, rd_out}, {27'd0, rd});
            end else begin
                checkOutput({tag, "_done"},  {31'd0, done},  32'd0);
                checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd1);
            end
        end
    endtask

    // Cycle after done: block idle, pulse gone, result still held
    task automatic idleCheck(input string tag, input logic [31:0] exp_res);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        #1;
        checkOutput({tag, "_idle_busy"},   {31'd0, busy},  32'd0);
        checkOutput({tag, "_idle_done"},   {31'd0, done},  32'd0);
        checkOutput({tag, "_idle_stall"},  {31'd0, stall}, 32'd0);
        checkOutput({tag, "_idle_result"}, result, exp_res);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        flush        = 1'b0;
        rst          = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);

        // Reset state
        #12;
        checkOutput("rst_busy",   {31'd0, busy},  32'd0);
        checkOutput("rst_stall",  {31'd0, stall}, 32'd0);
        checkOutput("rst_done",   {31'd0, done},  32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_rd",     {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Unsigned quotient and remainder
        runOp("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 34, 0);
        idleCheck("divu_100_7", 32'd14);
        runOp("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd6, 32'd2, 34, 0);
        idleCheck("remu_100_7", 32'd2);

        // Signed quotient and remainder sign handling
        runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 34, 0);
        idleCheck("div_m7_2", 32'hFFFF_FFFD);
        runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 34, 0);
        idleCheck("rem_m7_2", 32'hFFFF_FFFF);
        runOp("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, 34, 0);
        idleCheck("rem_7_m2", 32'd1);

        // Divide by zero resolves in one cycle
        runOp("div_5_0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 0);
        idleCheck("div_5_0", 32'hFFFF_FFFF);
        runOp("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1, 0);

        // Flush mid-operation: no done, result unchanged, restart works
        @(negedge clk);
        applyStimulus(1'b1, 3'b101, 32'd1000, 32'd10, 5'd7);
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 3'b101, 32'd1000, 32'd10, 5'd7);
            if (i == 10) flush = 1'b1;
            #1;
            checkOutput("flush_pre_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_busy",   {31'd0, busy},  32'd0);
        checkOutput("flush_stall",  {31'd0, stall}, 32'd0);
        checkOutput("flush_done",   {31'd0, done},  32'd0);
        checkOutput("flush_result", result, 32'd5);
        runOp("after_flush", 3'b101, 32'd1000, 32'd10, 5'd8, 32'd100, 34, 0);
        idleCheck("after_flush", 32'd100);

        // Flush wins over a simultaneous start
        applyStimulus(1'b1, 3'b101, 32'd100, 32'd7, 5'd3);
        flush = 1'b1;
        #1;
        checkOutput("flushwin_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(1'b0, 3'b101, 32'd100, 32'd7, 5'd3);
        #1;
        checkOutput("flushwin_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Signed overflow is a special case only for signed ops
        runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 0);
        idleCheck("div_ovf", 32'h8000_0000);
        runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 0);
        idleCheck("rem_ovf", 32'd0);
        runOp("divu_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 34, 0);
        idleCheck("divu_ovf", 32'd0);

        // Start while busy is ignored
        runOp("ignore_start", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 34, 5);
        idleCheck("ignore_start", 32'd14);

        // Asynchronous reset mid-operation, then a clean run
        applyStimulus(1'b1, 3'b101, 32'd1000, 32'd3, 5'd9);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 3'b101, 32'd1000, 32'd3, 5'd9);
            if (i == 20) rst = 1'b0;
        end
        #1;
        checkOutput("midrst_busy",   {31'd0, busy},  32'd0);
        checkOutput("midrst_stall",  {31'd0, stall}, 32'd0);
        checkOutput("midrst_done",   {31'd0, done},  32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_rd",     {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("postrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        runOp("after_rst", 3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 34, 0);
        idleCheck("after_rst", 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
